// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes, FSM states, step modes and the divide-by-zero quotient bit live here.
package muldiv_seq_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ITER = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    typedef enum logic {
        M_MUL = 1'b0,
        M_DIV = 1'b1
    } step_mode_e;

    // Every quotient bit is set on divide by zero.
    localparam logic DIV0_Q_BIT = 1'b1;

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the CPU control/register file and the mul/div unit.
// The master drives operands and commands; the slave returns status and Hi/Lo.
interface muldiv_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// Divide leaves bit 0 clear and reports the quotient bit separately.
module muldiv_seq_step
    import muldiv_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  step_mode_e         i_mode,
    input  logic [2*WIDTH-1:0] i_partial,
    input  logic [WIDTH-1:0]   i_operand,
    output logic [2*WIDTH-1:0] o_partial,
    output logic               o_qbit
);
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_upper;
    logic [WIDTH-1:0] w_diff;

    always_comb begin
        w_sum     = {1'b0, i_partial[2*WIDTH-1:WIDTH]} +
                    (i_partial[0] ? {1'b0, i_operand} : '0);
        // Remainder after the left shift needs one extra bit before the compare.
        w_upper   = i_partial[2*WIDTH-1:WIDTH-1];
        w_diff    = w_upper[WIDTH-1:0] - i_operand;
        o_qbit    = 1'b0;
        o_partial = '0;
        if (i_mode == M_MUL) begin
            o_partial = {w_sum, i_partial[WIDTH-1:1]};
        end else if (w_upper >= {1'b0, i_operand}) begin
            o_qbit    = 1'b1;
            o_partial = {w_diff, i_partial[WIDTH-2:0], 1'b0};
        end else begin
            o_partial = {w_upper[WIDTH-1:0], i_partial[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural Hi/Lo registers.
// Magnitudes iterate in r_part; signs are applied once in S_FIX.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic         i_clk,
    input  logic         i_clr,
    muldiv_seq_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    state_e             r_state, w_state_nxt;
    op_e                r_op, w_op;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_part, w_step_part, w_prod;
    logic [WIDTH-1:0]   r_opnd, r_hi, r_lo;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_hi_res, w_lo_res;
    logic               r_neg, r_rem_neg, r_div0, r_done;
    logic               w_accept, w_signed, w_div0, w_qbit;
    step_mode_e         w_mode;

    always_comb begin
        w_op     = op_e'(bus.op);
        w_accept = (r_state == S_IDLE) && bus.start;
        w_signed = op_is_signed(w_op);
        w_div0   = op_is_div(w_op) && (bus.b == '0);
        w_abs_a  = (w_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        w_abs_b  = (w_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        w_mode   = op_is_div(r_op) ? M_DIV : M_MUL;
    end

    muldiv_seq_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_mode    (w_mode),
        .i_partial (r_part),
        .i_operand (r_opnd),
        .o_partial (w_step_part),
        .o_qbit    (w_qbit)
    );

    always_comb begin
        w_prod   = r_neg ? -r_part : r_part;
        w_hi_res = w_prod[2*WIDTH-1:WIDTH];
        w_lo_res = w_prod[WIDTH-1:0];
        if (r_div0) begin
            w_lo_res = {WIDTH{DIV0_Q_BIT}};
            w_hi_res = r_part[WIDTH-1:0];
        end else if (op_is_div(r_op)) begin
            w_lo_res = r_neg ? -r_part[WIDTH-1:0] : r_part[WIDTH-1:0];
            w_hi_res = r_rem_neg ? -r_part[2*WIDTH-1:WIDTH] : r_part[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (bus.start) w_state_nxt = w_div0 ? S_FIX : S_ITER;
            S_ITER: if (r_cnt == CW'(1)) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_op      <= OP_MULT;
            r_cnt     <= '0;
            r_part    <= '0;
            r_opnd    <= '0;
            r_neg     <= 1'b0;
            r_rem_neg <= 1'b0;
            r_div0    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_op      <= w_op;
                r_cnt     <= CW'(WIDTH);
                // Divide by zero returns the raw dividend in Hi, so keep A unmodified.
                r_part    <= {{WIDTH{1'b0}}, (w_div0 ? bus.a : w_abs_a)};
                r_opnd    <= w_abs_b;
                r_neg     <= w_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                r_rem_neg <= w_signed && bus.a[WIDTH-1];
                r_div0    <= w_div0;
            end else if (r_state == S_IDLE) begin
                if (bus.mthi) r_hi <= bus.a;
                if (bus.mtlo) r_lo <= bus.a;
            end else if (r_state == S_ITER) begin
                r_cnt  <= r_cnt - CW'(1);
                r_part <= {w_step_part[2*WIDTH-1:1], w_step_part[0] | w_qbit};
            end else if (r_state == S_FIX) begin
                r_hi   <= w_hi_res;
                r_lo   <= w_lo_res;
                r_done <= 1'b1;
            end
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_seq;
    logic clk;
    logic clr;
    int   n_checks;
    int   n_pass;

    muldiv_seq_if #(.WIDTH(32)) bus ();

    muldiv_seq #(
        .WIDTH (32)
    ) dut (
        .i_clk (clk),
        .i_clr (clr),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: 64-bit integer arithmetic straight from the op definitions.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output int lat);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lat = 33;
        case (op)
            2'b00: p = 64'(sa * sb);
            2'b01: p = 64'(a) * 64'(b);
            2'b10: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    p  = {32'(sr), 32'(sq)};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else            p = {a % b, a / b};
            end
        endcase
        if (op[1] && b == 32'd0) lat = 1;
        hi = p[63:32];
        lo = p[31:0];
    endfunction

    // Issues one op from an idle, post-edge point; returns observed busy length and Done timing.
    task automatic run_op(input logic [1:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                          output int cyc, output logic early, output logic d_end,
                          output logic d_after);
        bus.start = 1'b1;
        bus.op    = op_v;
        bus.a     = a_v;
        bus.b     = b_v;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        cyc   = 0;
        early = 1'b0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (bus.done !== 1'b0) early = 1'b1;
            @(posedge clk); #1;
        end
        d_end = bus.done;
        @(posedge clk); #1;
        d_after = bus.done;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'd0)
            $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h want all zero",
                     bus.busy, bus.done, bus.hi, bus.lo);
        else n_pass++;
        clr = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset_release_busy: got %b want 0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [1:0]  ops [6] = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b10, 2'b01};
        logic [31:0] as  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFF9,
                                 32'h8000_0000, 32'h0000_0000};
        logic [31:0] bs  [6] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'h1234};
        logic [31:0] ehi [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] elo [6] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'd3, 32'hFFFF_FFFD,
                                 32'h8000_0000, 32'd0};
        int   cyc;
        logic early, d_end, d_after;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], cyc, early, d_end, d_after);
            n_checks++;
            if (bus.hi !== ehi[i] || bus.lo !== elo[i])
                $display("FAIL directed_%0d_result: got hi=%h lo=%h want hi=%h lo=%h",
                         i, bus.hi, bus.lo, ehi[i], elo[i]);
            else n_pass++;
            n_checks++;
            if (cyc != 33 || early || d_end !== 1'b1 || d_after !== 1'b0)
                $display("FAIL directed_%0d_timing: got busy=%0d early=%b done=%b after=%b want 33/0/1/0",
                         i, cyc, early, d_end, d_after);
            else n_pass++;
        end
    endtask

    task automatic test_div0();
        int   cyc;
        logic early, d_end, d_after;
        run_op(2'b11, 32'd5, 32'd0, cyc, early, d_end, d_after);
        n_checks++;
        if (bus.hi !== 32'd5 || bus.lo !== 32'hFFFF_FFFF)
            $display("FAIL divu_by_zero: got hi=%h lo=%h want hi=00000005 lo=ffffffff", bus.hi, bus.lo);
        else n_pass++;
        n_checks++;
        if (cyc != 1 || d_end !== 1'b1 || d_after !== 1'b0)
            $display("FAIL div0_timing: got busy=%0d done=%b after=%b want 1/1/0", cyc, d_end, d_after);
        else n_pass++;
        run_op(2'b10, 32'hFFFF_FFF0, 32'd0, cyc, early, d_end, d_after);
        n_checks++;
        if (bus.hi !== 32'hFFFF_FFF0 || bus.lo !== 32'hFFFF_FFFF || cyc != 1)
            $display("FAIL div_signed_by_zero: got hi=%h lo=%h busy=%0d want fffffff0/ffffffff/1",
                     bus.hi, bus.lo, cyc);
        else n_pass++;
    endtask

    task automatic test_ignore_busy();
        int cyc;
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd3; bus.b = 32'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd9; bus.b = 32'd3; bus.mthi = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mthi = 1'b0;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd12 || bus.done !== 1'b1)
            $display("FAIL ignore_while_busy: got hi=%h lo=%h done=%b want 0/0000000c/1",
                     bus.hi, bus.lo, bus.done);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.lo !== 32'd12)
            $display("FAIL no_queued_start: got busy=%b lo=%h want 0/0000000c", bus.busy, bus.lo);
        else n_pass++;
    endtask

    task automatic test_mt();
        int cyc;
        bus.mthi = 1'b1; bus.a = 32'h1234;
        @(posedge clk); #1;
        bus.mthi = 1'b0;
        n_checks++;
        if (bus.hi !== 32'h1234 || bus.lo !== 32'd12 || bus.done !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL mthi: got hi=%h lo=%h done=%b busy=%b want 00001234/0000000c/0/0",
                     bus.hi, bus.lo, bus.done, bus.busy);
        else n_pass++;
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.a = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        n_checks++;
        if (bus.hi !== 32'hCAFE_F00D || bus.lo !== 32'hCAFE_F00D || bus.done !== 1'b0)
            $display("FAIL mthi_mtlo: got hi=%h lo=%h done=%b want cafef00d/cafef00d/0",
                     bus.hi, bus.lo, bus.done);
        else n_pass++;
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd2; bus.b = 32'd3;
        bus.mthi = 1'b1; bus.mtlo = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        n_checks++;
        if (bus.hi !== 32'hCAFE_F00D || bus.lo !== 32'hCAFE_F00D || bus.busy !== 1'b1)
            $display("FAIL start_beats_mt: got hi=%h lo=%h busy=%b want cafef00d/cafef00d/1",
                     bus.hi, bus.lo, bus.busy);
        else n_pass++;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd6)
            $display("FAIL start_beats_mt_result: got hi=%h lo=%h want 0/00000006", bus.hi, bus.lo);
        else n_pass++;
    endtask

    task automatic test_clr_abort();
        int   cyc;
        logic early, d_end, d_after;
        logic seen_done;
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd6; bus.b = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        clr = 1'b1;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.done !== 1'b0)
            $display("FAIL clr_abort: got busy=%b hi=%h lo=%h done=%b want 0/0/0/0",
                     bus.busy, bus.hi, bus.lo, bus.done);
        else n_pass++;
        @(posedge clk); #1;
        clr = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen_done = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen_done || bus.lo !== 32'd0)
            $display("FAIL clr_no_done: got stray_activity=%b lo=%h want 0/0", seen_done, bus.lo);
        else n_pass++;
        run_op(2'b00, 32'd6, 32'd7, cyc, early, d_end, d_after);
        n_checks++;
        if (bus.lo !== 32'd42 || bus.hi !== 32'd0 || cyc != 33)
            $display("FAIL restart_after_clr: got hi=%h lo=%h busy=%0d want 0/0000002a/33",
                     bus.hi, bus.lo, cyc);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b, ehi, elo;
        int          lat, cyc, sel;
        logic        early, d_end, d_after;
        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0)      b = 32'd0;
            else if (sel == 1) b = $urandom_range(1, 15);
            else if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 3) a = $urandom_range(0, 100);
            model(op, a, b, ehi, elo, lat);
            run_op(op, a, b, cyc, early, d_end, d_after);
            n_checks++;
            if (bus.hi !== ehi || bus.lo !== elo)
                $display("FAIL random_%0d op=%0d a=%h b=%h: got hi=%h lo=%h want hi=%h lo=%h",
                         i, op, a, b, bus.hi, bus.lo, ehi, elo);
            else n_pass++;
            n_checks++;
            if (cyc != lat || early || d_end !== 1'b1 || d_after !== 1'b0)
                $display("FAIL random_%0d_timing: got busy=%0d early=%b done=%b after=%b want %0d/0/1/0",
                         i, cyc, early, d_end, d_after, lat);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_directed();
        test_div0();
        test_ignore_busy();
        test_mt();
        test_clr_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle CPU.
- Sits directly downstream of the register file: takes the two read ports (Qa→A, Qb→B) as operands.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and holds results in Hi/Lo for MFHI/MFLO.
- Control stalls the PC while Busy=1.

Parameters:
- WIDTH, 32, operand/result width; counter width = clog2(WIDTH)+1.

Ports:
- Clk  in  1  clock, rising edge
- Clr  in  1  reset, asynchronous, active-high
- Start  in  1  begin operation Op on A,B (accepted only in IDLE)
- Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- A  in  WIDTH  operand rs (multiplicand/dividend); also MTHI/MTLO data
- B  in  WIDTH  operand rt (multiplier/divisor)
- Mthi  in  1  write A to Hi (IDLE only)
- Mtlo  in  1  write A to Lo (IDLE only)
- Busy  out  1  operation in progress
- Done  out  1  one-cycle pulse, Hi/Lo just updated by an operation
- Hi  out  WIDTH  HI register
- Lo  out  WIDTH  LO register

Behaviour:
- Reset (async, Clr=1): state=IDLE, Hi=Lo=0, Busy=0, Done=0, internal accumulators/counter=0. Clr mid-operation aborts; no partial result reaches Hi/Lo.
- States: IDLE, ITER, FIX. Busy = (state != IDLE), combinational from state.
- Accept edge E0: state=IDLE and Start=1.
  - Capture operands; for signed ops store |A|, |B| and sign flags.
  - Counter = WIDTH; next state ITER.
- ITER: one radix-2 step per edge; counter decrements; the edge where counter reaches 0 moves to FIX.
  - Multiply: shift-add on the 2*WIDTH-bit product.
  - Divide: restoring shift-subtract; quotient bit = 1 when partial remainder ≥ divisor.
- FIX: apply signs and load Hi/Lo at the closing edge; next state IDLE; Done=1 for the following cycle only.
  - Signed multiply: negate the 2W product when signs differ; Hi = upper W bits, Lo = lower W bits.
  - Signed divide: quotient negated when signs differ; remainder takes the dividend's sign; Lo = quotient, Hi = remainder.
- Latency (WIDTH=32): iterations on edges E1..E32, Hi/Lo loaded at E33, Busy=1 for 33 cycles, Done=1 in the cycle after E33.
- Divide by zero (B=0 at E0): skip ITER, go straight to FIX. Result Lo = all ones, Hi = A (raw, unsigned or signed op alike). Hi/Lo loaded at E1, Busy 1 cycle.
- Signed overflow (0x80000000 / 0xFFFFFFFF): Lo=0x80000000, Hi=0; normal latency.
- Start, Mthi, Mtlo while Busy=1: ignored, no queuing.
- Start together with Mthi/Mtlo in IDLE: Start wins; the Mt write is dropped.
- Mthi and Mtlo together in IDLE: both registers load A.
- Mt writes take effect at the edge, never assert Done, and never change Busy.
- Hi/Lo hold their value at all times except these load points.

Decomposition:
- Shared package:
  - Op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU).
  - State encodings (S_IDLE, S_ITER, S_FIX).
  - Divide-by-zero quotient constant.
- Sub-module muldiv_step: purely combinational single-iteration datapath for the shift-add or shift-subtract step. Inputs: mode, partial, operand. Outputs: next partial, next quotient bit.
- FSM, counter, sign fix-up and Hi/Lo live in the top.

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF → Busy high 33 cycles; Done the cycle after E33; Hi=0xFFFFFFFE, Lo=0x00000001.
- MULT A=0xFFFFFFFD(-3) B=7 → Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. DIVU A=7 B=2 → Lo=3, Hi=1.
- DIV A=0xFFFFFFF9(-7) B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIV A=0x80000000 B=0xFFFFFFFF → Lo=0x80000000, Hi=0.
- DIVU A=5 B=0 → Busy 1 cycle; Lo=0xFFFFFFFF, Hi=5; Done next cycle.
- Start MULTU 3×4, then Start (DIV 9/3) and Mthi pulsed at cycle 10 → both ignored; Hi=0, Lo=12. Later Mthi with A=0x1234 in IDLE → Hi=0x1234, Done stays 0.
- Start MULT 6×7, assert Clr at cycle 15 for 1 cycle → Busy=0, Hi=Lo=0, no Done pulse. A new Start 6×7 completes with Lo=42.
